// File: rtl/product_order_client.sv
// Initiator end of the product-factory interface: issues one order at a time to a responder,
// decodes the returned product back to its config byte and reports a status-tagged result.
module product_order_client #(
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ord_valid,
    output logic             ord_ready,
    input  logic [1:0]       ord_type,
    input  logic [7:0]       ord_data,
    output logic [1:0]       fac_select,
    output logic [7:0]       fac_config,
    input  logic [7:0]       fac_output,
    input  logic             fac_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [1:0]       res_status,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(DRAIN_CYC - 1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_BAD_TYPE = 2'b11;

    typedef enum logic [1:0] {StIdle, StWait, StResp, StDrain} state_t;

    state_t        state;
    logic [1:0]    ord_type_l;
    logic [7:0]    ord_data_l;
    logic [TW-1:0] tmo_cnt;
    logic [DW-1:0] drn_cnt;
    logic [7:0]    dec_data;
    logic          dec_ok;
    logic          type_ok;

    // Gated with rst_n so no order can be accepted while reset is held.
    assign ord_ready = (state == StIdle) && rst_n;
    assign busy      = (state != StIdle);
    assign type_ok   = (ord_type == 2'b01) || (ord_type == 2'b10);

    // Product B loses config bit 7 in the shift, so only bits 6:0 are compared.
    always_comb begin
        dec_data = 8'h00;
        dec_ok   = 1'b0;
        if (ord_type_l == 2'b01) begin
            dec_data = fac_output - 8'd10;
            dec_ok   = (dec_data == ord_data_l);
        end else begin
            dec_data = {1'b0, fac_output[7:1]};
            dec_ok   = !fac_output[0] && (dec_data[6:0] == ord_data_l[6:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            ord_type_l <= 2'b00;
            ord_data_l <= 8'h00;
            fac_select <= 2'b00;
            fac_config <= 8'h00;
            res_valid  <= 1'b0;
            res_data   <= 8'h00;
            res_status <= ST_OK;
            err_count  <= '0;
            tmo_cnt    <= '0;
            drn_cnt    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    fac_select <= 2'b00;
                    if (ord_valid) begin
                        ord_type_l <= ord_type;
                        ord_data_l <= ord_data;
                        if (type_ok) begin
                            fac_select <= ord_type;
                            fac_config <= ord_data;
                            tmo_cnt    <= '0;
                            state      <= StWait;
                        end else begin
                            res_valid  <= 1'b1;
                            res_data   <= ord_data;
                            res_status <= ST_BAD_TYPE;
                            state      <= StResp;
                        end
                    end
                end
                StWait: begin
                    // A product arriving on the last allowed cycle still wins over timeout.
                    if (fac_valid) begin
                        fac_select <= 2'b00;
                        res_valid  <= 1'b1;
                        res_data   <= dec_data;
                        res_status <= dec_ok ? ST_OK : ST_MISMATCH;
                        state      <= StResp;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fac_select <= 2'b00;
                        res_valid  <= 1'b1;
                        res_data   <= 8'h00;
                        res_status <= ST_TIMEOUT;
                        state      <= StResp;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StResp: begin
                    fac_select <= 2'b00;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if ((res_status != ST_OK) && (err_count != '1)) begin
                            err_count <= err_count + 1'b1;
                        end
                        drn_cnt <= '0;
                        state   <= StDrain;
                    end
                end
                StDrain: begin
                    fac_select <= 2'b00;
                    if (drn_cnt == DRN_LAST) begin
                        state <= StIdle;
                    end else begin
                        drn_cnt <= drn_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_product_order_client.sv
// Randomized self-checking bench for product_order_client with a two-stage responder model.
module tb_product_order_client;

    localparam int TIMEOUT   = 8;
    localparam int DRAIN_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ord_valid = 1'b0;
    logic       ord_ready;
    logic [1:0] ord_type = 2'b00;
    logic [7:0] ord_data = 8'h00;
    logic [1:0] fac_select;
    logic [7:0] fac_config;
    logic [7:0] fac_output;
    logic       fac_valid;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [1:0] res_status;
    logic [7:0] err_count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    // Responder: 0 normal, 1 forced value, 2 silent, 3 silent but injected product at deadline.
    int         mode = 0;
    logic [7:0] force_val = 8'h00;
    logic       inj = 1'b0;
    logic       s1_v, s2_v;
    logic [7:0] s1_d, s2_d;

    always #5 clk = ~clk;

    product_order_client #(
        .TIMEOUT  (TIMEOUT),
        .DRAIN_CYC(DRAIN_CYC),
        .ERR_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ord_valid (ord_valid),
        .ord_ready (ord_ready),
        .ord_type  (ord_type),
        .ord_data  (ord_data),
        .fac_select(fac_select),
        .fac_config(fac_config),
        .fac_output(fac_output),
        .fac_valid (fac_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_status(res_status),
        .err_count (err_count),
        .busy      (busy)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_d <= 8'h00;
            s2_d <= 8'h00;
        end else begin
            s1_v <= (fac_select != 2'b00) && (mode == 0 || mode == 1);
            if (mode == 1)
                s1_d <= force_val;
            else if (fac_select == 2'b01)
                s1_d <= fac_config + 8'd10;
            else
                s1_d <= {fac_config[6:0], 1'b0};
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
    end

    assign fac_valid  = s2_v | inj;
    assign fac_output = s2_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model straight from the product rules.
    task automatic predict(input int t, input int d, input int md, input int fv,
                           output int e_data, output int e_stat, output int e_lat);
        int prod, rd;
        if (t != 1 && t != 2) begin
            e_data = d; e_stat = 3; e_lat = 0;
        end else if (md == 2) begin
            e_data = 0; e_stat = 2; e_lat = TIMEOUT;
        end else begin
            if (md == 1) prod = fv;
            else if (t == 1) prod = (d + 10) % 256;
            else prod = (d * 2) % 256;
            e_lat = (md == 3) ? TIMEOUT : 3;
            if (t == 1) begin
                rd = (prod - 10 + 256) % 256;
                e_stat = (rd == d) ? 0 : 1;
            end else begin
                rd = prod / 2;
                e_stat = (prod % 2 == 0 && rd % 128 == d % 128) ? 0 : 1;
            end
            e_data = rd;
        end
    endtask

    task automatic run_order(input int t, input int d, input int md, input int fv,
                             input int hold, input bit drain_pulse);
        int e_data, e_stat, e_lat, edges, dn;
        predict(t, d, md, fv, e_data, e_stat, e_lat);
        mode = md;
        force_val = 8'(fv);
        dn = 0;
        while (!ord_ready && dn < 20) begin
            @(negedge clk);
            dn++;
        end
        check("ord_ready_idle", {31'd0, ord_ready}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        ord_valid = 1'b1;
        ord_type  = 2'(t);
        ord_data  = 8'(d);
        @(negedge clk);
        ord_valid = 1'b0;
        ord_type  = 2'($urandom_range(0, 3));
        ord_data  = 8'($urandom);
        if (e_stat != 3) begin
            check("sel_load", {30'd0, fac_select}, 32'(t));
            check("cfg_load", {24'd0, fac_config}, 32'(d));
        end
        edges = 0;
        while (!res_valid && edges < 40) begin
            check("sel_wait", {30'd0, fac_select}, 32'(t));
            check("ord_ready_busy", {31'd0, ord_ready}, 32'd0);
            if (md == 3 && edges == TIMEOUT - 1) inj = 1'b1;
            @(negedge clk);
            inj = 1'b0;
            edges++;
        end
        check("latency", 32'(edges), 32'(e_lat));
        check("res_data", {24'd0, res_data}, 32'(e_data));
        check("res_status", {30'd0, res_status}, 32'(e_stat));
        check("sel_resp", {30'd0, fac_select}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", {24'd0, res_data}, 32'(e_data));
            check("hold_status", {30'd0, res_status}, 32'(e_stat));
            check("hold_ord_ready", {31'd0, ord_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        if (e_stat != 0 && exp_err < 255) exp_err++;
        check("res_valid_drop", {31'd0, res_valid}, 32'd0);
        check("busy_drain", {31'd0, busy}, 32'd1);
        check("err_count", {24'd0, err_count}, 32'(exp_err));
        inj = drain_pulse;
        dn = 0;
        while (!ord_ready && dn < 20) begin
            @(negedge clk);
            dn++;
        end
        inj = 1'b0;
        check("drain_len", 32'(dn), 32'(DRAIN_CYC));
        check("drain_no_res", {31'd0, res_valid}, 32'd0);
        check("drain_err", {24'd0, err_count}, 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_ord_ready", {31'd0, ord_ready}, 32'd0);
        check("rst_sel", {30'd0, fac_select}, 32'd0);
        check("rst_cfg", {24'd0, fac_config}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_res_status", {30'd0, res_status}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_order(1, 8'h05, 0, 0, 0, 1'b0);
        run_order(2, 8'h85, 0, 0, 0, 1'b0);
        run_order(1, 8'hFA, 0, 0, 0, 1'b0);
        run_order(1, 8'h05, 1, 8'h10, 0, 1'b0);
        run_order(2, 8'h05, 1, 8'h0B, 0, 1'b0);
        run_order(1, 8'h33, 2, 0, 0, 1'b1);
        run_order(2, 8'h41, 3, 0, 0, 1'b0);
        run_order(3, 8'hA7, 0, 0, 5, 1'b0);
        run_order(0, 8'h5C, 0, 0, 5, 1'b1);

        // Stray product pulses in IDLE must be ignored.
        inj = 1'b1;
        repeat (3) @(negedge clk);
        inj = 1'b0;
        check("idle_pulse_busy", {31'd0, busy}, 32'd0);
        check("idle_pulse_res", {31'd0, res_valid}, 32'd0);
        check("idle_pulse_err", {24'd0, err_count}, 32'(exp_err));

        for (int n = 0; n < 40; n++) begin
            int r, md;
            r  = $urandom_range(0, 9);
            md = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            run_order($urandom_range(0, 3), $urandom_range(0, 255), md, $urandom_range(0, 255),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset mid-WAIT discards the order.
        mode = 2;
        ord_valid = 1'b1;
        ord_type  = 2'b01;
        ord_data  = 8'h05;
        @(negedge clk);
        ord_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", {30'd0, fac_select}, 32'd0);
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ord_ready", {31'd0, ord_ready}, 32'd0);
        check("mid_rst_err", {24'd0, err_count}, 32'd0);
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_order(1, 8'h05, 0, 0, 0, 1'b0);

        // Drive the error counter into saturation.
        for (int n = 0; n < 258; n++) begin
            run_order(1, 8'h05, 1, 8'h10, 0, 1'b0);
        end
        check("err_saturated", {24'd0, err_count}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
